// File: rtl/noc_inject_sched_if.sv
// Bundle of the source-side handshake, the flit channel toward the router,
// and the per-VC credit return and status lines.
interface noc_inject_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int NUM_VCS = 2,
  parameter int DATA_W  = 32
);
  localparam int VC_W = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

  logic [NUM_REQ-1:0]        src_valid;
  logic [NUM_REQ*DATA_W-1:0] src_data;
  logic [NUM_REQ-1:0]        src_last;
  logic [NUM_REQ-1:0]        src_ready;
  logic                      flit_valid;
  logic [VC_W-1:0]           flit_vc;
  logic                      flit_head;
  logic                      flit_tail;
  logic [DATA_W-1:0]         flit_data;
  logic [NUM_VCS-1:0]        credit_in;
  logic                      busy;
  logic                      credit_err;

  // Environment side: packet sources plus the router's credit return.
  modport master (
    output src_valid, src_data, src_last, credit_in,
    input  src_ready, flit_valid, flit_vc, flit_head, flit_tail, flit_data,
           busy, credit_err
  );

  // Scheduler side.
  modport slave (
    input  src_valid, src_data, src_last, credit_in,
    output src_ready, flit_valid, flit_vc, flit_head, flit_tail, flit_data,
           busy, credit_err
  );
endinterface

// File: rtl/noc_inject_sched.sv
// Injection scheduler for a router local port: packet-level round-robin
// across sources, per-packet VC choice, per-VC credit tracking, and
// head/tail-tagged flit output one cycle after each source handshake.
//
// state | meaning
// IDLE  | arbitrating; a grant needs a valid source and a VC with credit
// SEND  | wormhole: owner and vc locked until the tail handshake
module noc_inject_sched #(
  parameter int NUM_REQ = 4,
  parameter int NUM_VCS = 2,
  parameter int CREDITS = 4,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               arst,
  noc_inject_sched_if.slave  bus
);
  localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int VC_W  = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam int CNT_W = $clog2(CREDITS + 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [REQ_W-1:0]   owner, req_ptr, req_pick;
  logic [VC_W-1:0]    vc, vc_ptr, vc_pick;
  logic               req_found, vc_found;
  logic               first;
  logic               grant, hs;
  logic [NUM_REQ-1:0] ready;
  logic [CNT_W-1:0]   credit [NUM_VCS];
  logic [NUM_VCS-1:0] vc_has, send_vc, overflow;

  // Per-VC credit availability, send strobe and overflow detection.
  always_comb begin
    vc_has   = '0;
    send_vc  = '0;
    overflow = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      vc_has[v]   = (credit[v] != '0);
      send_vc[v]  = hs && (int'(vc) == v);
      overflow[v] = bus.credit_in[v] && !send_vc[v] &&
                    (credit[v] == CNT_W'(CREDITS));
    end
  end

  // Round-robin search: first valid source and first VC with credit,
  // each starting one past its pointer.
  always_comb begin
    int idx;
    idx       = 0;
    req_found = 1'b0;
    req_pick  = '0;
    vc_found  = 1'b0;
    vc_pick   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(req_ptr) + k) % NUM_REQ;
      if (!req_found && bus.src_valid[idx]) begin
        req_found = 1'b1;
        req_pick  = REQ_W'(idx);
      end
    end
    for (int k = 1; k <= NUM_VCS; k++) begin
      idx = (int'(vc_ptr) + k) % NUM_VCS;
      if (!vc_found && vc_has[idx]) begin
        vc_found = 1'b1;
        vc_pick  = VC_W'(idx);
      end
    end
  end

  // Next state, grant and source accept strobes.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    hs        = 1'b0;
    ready     = '0;
    case (state)
      IDLE: begin
        if (req_found && vc_found) begin
          grant     = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (bus.src_valid[owner] && vc_has[vc]) begin
          ready[owner] = 1'b1;
          hs           = 1'b1;
          if (bus.src_last[owner]) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.src_ready = ready;
  assign bus.busy      = (state == SEND);

  // State register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Grant bookkeeping: owner/vc lock, round-robin pointers, first-flit flag.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      owner   <= '0;
      vc      <= '0;
      req_ptr <= REQ_W'(NUM_REQ - 1);
      vc_ptr  <= VC_W'(NUM_VCS - 1);
      first   <= 1'b0;
    end else if (grant) begin
      owner   <= req_pick;
      vc      <= vc_pick;
      req_ptr <= req_pick;
      vc_ptr  <= vc_pick;
      first   <= 1'b1;
    end else if (hs) begin
      first   <= 1'b0;
    end
  end

  // Credit counters; a return into a full counter saturates and is flagged.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int v = 0; v < NUM_VCS; v++) credit[v] <= CNT_W'(CREDITS);
      bus.credit_err <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (send_vc[v] && !bus.credit_in[v])
          credit[v] <= credit[v] - 1'b1;
        else if (bus.credit_in[v] && !send_vc[v] && !overflow[v])
          credit[v] <= credit[v] + 1'b1;
      end
      if (|overflow) bus.credit_err <= 1'b1;
    end
  end

  // Registered flit channel; payload fields hold when no flit is sent.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      bus.flit_valid <= 1'b0;
      bus.flit_vc    <= '0;
      bus.flit_head  <= 1'b0;
      bus.flit_tail  <= 1'b0;
      bus.flit_data  <= '0;
    end else begin
      bus.flit_valid <= hs;
      if (hs) begin
        bus.flit_vc   <= vc;
        bus.flit_head <= first;
        bus.flit_tail <= bus.src_last[owner];
        bus.flit_data <= bus.src_data[int'(owner)*DATA_W +: DATA_W];
      end
    end
  end
endmodule

// File: tb/tb_noc_inject_sched.sv
// Directed bench for noc_inject_sched: per-cycle vector tables for the
// single-packet and round-robin cases, hand sequences for credit stall,
// VC skip, simultaneous send/return, overflow and mid-packet reset.
module tb_noc_inject_sched;
  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  noc_inject_sched_if #(.NUM_REQ(4), .NUM_VCS(2), .DATA_W(32)) ia ();
  noc_inject_sched_if #(.NUM_REQ(4), .NUM_VCS(2), .DATA_W(32)) ib ();

  noc_inject_sched #(.NUM_REQ(4), .NUM_VCS(2), .CREDITS(4), .DATA_W(32))
    dut_a (.clk(clk), .arst(arst), .bus(ia));
  noc_inject_sched #(.NUM_REQ(4), .NUM_VCS(2), .CREDITS(2), .DATA_W(32))
    dut_b (.clk(clk), .arst(arst), .bus(ib));

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic [1:0]  c;
    logic [3:0]  e_ready;
    logic        e_fv;
    logic        e_h;
    logic        e_t;
    logic        e_vc;
    logic [31:0] e_d;
    logic        e_busy;
  } vec_t;

  vec_t t_single[$];
  vec_t t_rr[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic rst, logic [3:0] v, logic [3:0] l, logic [31:0] d,
                              logic [1:0] c, logic [3:0] er, logic efv, logic eh,
                              logic et, logic evc, logic [31:0] ed, logic eb);
    vec_t r;
    r.rst = rst; r.v = v; r.l = l; r.d = d; r.c = c; r.e_ready = er;
    r.e_fv = efv; r.e_h = eh; r.e_t = et; r.e_vc = evc; r.e_d = ed; r.e_busy = eb;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Source i carries payload d+i so the owner selection is visible.
  task automatic drv_a(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                       input logic [1:0] c);
    ia.src_valid = v;
    ia.src_last  = l;
    for (int i = 0; i < 4; i++) ia.src_data[i*32 +: 32] = d + i;
    ia.credit_in = c;
  endtask

  task automatic drv_b(input logic v, input logic l, input logic [31:0] d, input logic c);
    ib.src_valid = {3'b000, v};
    ib.src_last  = {3'b000, l};
    ib.src_data  = '0;
    ib.src_data[31:0] = d;
    ib.credit_in = {1'b0, c};
  endtask

  task automatic do_reset();
    drv_a(4'h0, 4'h0, 32'h0, 2'b00);
    drv_b(1'b0, 1'b0, 32'h0, 1'b0);
    arst = 1'b1;
    tick();
    tick();
    arst = 1'b0;
  endtask

  task automatic run_vecs(input vec_t q[$], input string tag);
    foreach (q[n]) begin
      if (q[n].rst) do_reset();
      drv_a(q[n].v, q[n].l, q[n].d, q[n].c);
      #1;
      chk($sformatf("%s[%0d].ready", tag, n), ia.src_ready, q[n].e_ready);
      tick();
      chk($sformatf("%s[%0d].fv", tag, n), ia.flit_valid, q[n].e_fv);
      chk($sformatf("%s[%0d].busy", tag, n), ia.busy, q[n].e_busy);
      if (q[n].e_fv) begin
        chk($sformatf("%s[%0d].head", tag, n), ia.flit_head, q[n].e_h);
        chk($sformatf("%s[%0d].tail", tag, n), ia.flit_tail, q[n].e_t);
        chk($sformatf("%s[%0d].vc", tag, n), ia.flit_vc, q[n].e_vc);
        chk($sformatf("%s[%0d].data", tag, n), ia.flit_data, q[n].e_d);
      end
    end
  endtask

  initial begin
    //                      rst v     l     d      c      ready fv h t vc data    busy
    t_single.push_back(mk(1, 4'h1, 4'h0, 32'h11, 2'b00, 4'h0, 0, 0, 0, 0, 32'h0,  1));
    t_single.push_back(mk(0, 4'h1, 4'h0, 32'h11, 2'b00, 4'h1, 1, 1, 0, 0, 32'h11, 1));
    t_single.push_back(mk(0, 4'h1, 4'h0, 32'h22, 2'b00, 4'h1, 1, 0, 0, 0, 32'h22, 1));
    t_single.push_back(mk(0, 4'h1, 4'h1, 32'h33, 2'b00, 4'h1, 1, 0, 1, 0, 32'h33, 0));
    t_single.push_back(mk(0, 4'h0, 4'h0, 32'h0,  2'b00, 4'h0, 0, 0, 0, 0, 32'h0,  0));

    t_rr.push_back(mk(1, 4'hF, 4'hF, 32'h100, 2'b00, 4'h0, 0, 0, 0, 0, 32'h0,   1));
    t_rr.push_back(mk(0, 4'hF, 4'hF, 32'h100, 2'b00, 4'h1, 1, 1, 1, 0, 32'h100, 0));
    t_rr.push_back(mk(0, 4'hF, 4'hF, 32'h100, 2'b01, 4'h0, 0, 0, 0, 0, 32'h0,   1));
    t_rr.push_back(mk(0, 4'hF, 4'hF, 32'h100, 2'b00, 4'h2, 1, 1, 1, 1, 32'h101, 0));
    t_rr.push_back(mk(0, 4'hF, 4'hF, 32'h100, 2'b10, 4'h0, 0, 0, 0, 0, 32'h0,   1));
    t_rr.push_back(mk(0, 4'hF, 4'hF, 32'h100, 2'b00, 4'h4, 1, 1, 1, 0, 32'h102, 0));
    t_rr.push_back(mk(0, 4'hF, 4'hF, 32'h100, 2'b01, 4'h0, 0, 0, 0, 0, 32'h0,   1));
    t_rr.push_back(mk(0, 4'hF, 4'hF, 32'h100, 2'b00, 4'h8, 1, 1, 1, 1, 32'h103, 0));
    t_rr.push_back(mk(0, 4'hF, 4'hF, 32'h100, 2'b10, 4'h0, 0, 0, 0, 0, 32'h0,   1));
    t_rr.push_back(mk(0, 4'hF, 4'hF, 32'h100, 2'b00, 4'h1, 1, 1, 1, 0, 32'h100, 0));

    arst = 1'b1;
    drv_a(4'h0, 4'h0, 32'h0, 2'b00);
    drv_b(1'b0, 1'b0, 32'h0, 1'b0);
    do_reset();

    // Reset state
    chk("rst.fv", ia.flit_valid, 1'b0);
    chk("rst.busy", ia.busy, 1'b0);
    chk("rst.err", ia.credit_err, 1'b0);
    chk("rst.ready", ia.src_ready, 4'h0);
    chk("rst.cred_a0", dut_a.credit[0], 3'd4);
    chk("rst.cred_b1", dut_b.credit[1], 2'd2);

    // Single 3-flit packet from source 0
    run_vecs(t_single, "single");
    chk("single.cred0", dut_a.credit[0], 3'd1);
    chk("single.cred1", dut_a.credit[1], 3'd4);

    // Round robin over four 1-flit sources
    run_vecs(t_rr, "rr");

    // Credit stall on the CREDITS=2 instance
    do_reset();
    drv_b(1'b1, 1'b0, 32'hE0, 1'b0); tick();
    chk("stall.busy", ib.busy, 1'b1);
    drv_b(1'b1, 1'b0, 32'hE0, 1'b0); #1;
    chk("stall.ready0", ib.src_ready, 4'h1); tick();
    chk("stall.fv0", ib.flit_valid, 1'b1);
    chk("stall.head0", ib.flit_head, 1'b1);
    drv_b(1'b1, 1'b0, 32'hE1, 1'b0); #1;
    chk("stall.ready1", ib.src_ready, 4'h1); tick();
    chk("stall.data1", ib.flit_data, 32'hE1);
    for (int k = 0; k < 3; k++) begin
      drv_b(1'b1, 1'b0, 32'hE2, 1'b0); #1;
      chk($sformatf("stall.hold_ready%0d", k), ib.src_ready, 4'h0); tick();
      chk($sformatf("stall.hold_fv%0d", k), ib.flit_valid, 1'b0);
    end
    drv_b(1'b1, 1'b0, 32'hE2, 1'b1); #1;
    chk("stall.ret_ready", ib.src_ready, 4'h0); tick();
    chk("stall.ret_fv", ib.flit_valid, 1'b0);
    chk("stall.ret_cred", dut_b.credit[0], 2'd1);
    drv_b(1'b1, 1'b0, 32'hE2, 1'b0); #1;
    chk("stall.go_ready", ib.src_ready, 4'h1); tick();
    chk("stall.go_fv", ib.flit_valid, 1'b1);
    chk("stall.go_data", ib.flit_data, 32'hE2);
    drv_b(1'b1, 1'b1, 32'hE3, 1'b0); #1;
    chk("stall.again_ready", ib.src_ready, 4'h0); tick();
    chk("stall.again_fv", ib.flit_valid, 1'b0);
    drv_b(1'b0, 1'b0, 32'h0, 1'b0);

    // VC skip: drain vc0, leave vc1 at 3 with the pointer on vc1
    do_reset();
    drv_a(4'h1, 4'h0, 32'hA0, 2'b00); tick();
    for (int k = 0; k < 4; k++) begin
      drv_a(4'h1, (k == 3) ? 4'h1 : 4'h0, 32'hA0 + k, 2'b00); tick();
    end
    chk("skip.cred0", dut_a.credit[0], 3'd0);
    drv_a(4'h1, 4'h1, 32'hB0, 2'b00); tick(); tick();
    chk("skip.one_fv", ia.flit_valid, 1'b1);
    chk("skip.one_vc", ia.flit_vc, 1'b1);
    chk("skip.cred1", dut_a.credit[1], 3'd3);
    drv_a(4'h1, 4'h0, 32'hC0, 2'b00); tick();
    chk("skip.busy", ia.busy, 1'b1);
    tick();
    chk("skip.vc", ia.flit_vc, 1'b1);
    chk("skip.head", ia.flit_head, 1'b1);
    drv_a(4'h1, 4'h0, 32'hC1, 2'b00); tick();
    drv_a(4'h1, 4'h1, 32'hC2, 2'b00); tick();
    chk("skip.tail", ia.flit_tail, 1'b1);
    chk("skip.cred1_empty", dut_a.credit[1], 3'd0);
    drv_a(4'hF, 4'h0, 32'hD0, 2'b00);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("nocred.ready%0d", k), ia.src_ready, 4'h0); tick();
      chk($sformatf("nocred.busy%0d", k), ia.busy, 1'b0);
      chk($sformatf("nocred.fv%0d", k), ia.flit_valid, 1'b0);
    end

    // Send and credit return in the same cycle at credit 1
    do_reset();
    drv_a(4'h1, 4'h0, 32'hD0, 2'b00); tick();
    for (int k = 0; k < 5; k++) begin
      drv_a(4'h1, (k == 4) ? 4'h1 : 4'h0, 32'hD0 + k, (k == 3) ? 2'b01 : 2'b00); #1;
      chk($sformatf("simul.ready%0d", k), ia.src_ready, 4'h1); tick();
      chk($sformatf("simul.fv%0d", k), ia.flit_valid, 1'b1);
      if (k == 3) chk("simul.cred_hold", dut_a.credit[0], 3'd1);
    end
    chk("simul.tail", ia.flit_tail, 1'b1);
    chk("simul.cred_end", dut_a.credit[0], 3'd0);

    // Overflow on a full counter, then reset mid-packet
    drv_a(4'h0, 4'h0, 32'h0, 2'b10); tick();
    chk("err.set", ia.credit_err, 1'b1);
    chk("err.cred1", dut_a.credit[1], 3'd4);
    drv_a(4'h0, 4'h0, 32'h0, 2'b00); tick();
    chk("err.sticky", ia.credit_err, 1'b1);
    drv_a(4'h1, 4'h0, 32'hF0, 2'b00); tick();
    tick();
    chk("mid.fv", ia.flit_valid, 1'b1);
    chk("mid.vc", ia.flit_vc, 1'b1);
    arst = 1'b1;
    #1;
    chk("arst.fv", ia.flit_valid, 1'b0);
    chk("arst.head", ia.flit_head, 1'b0);
    chk("arst.tail", ia.flit_tail, 1'b0);
    chk("arst.vc", ia.flit_vc, 1'b0);
    chk("arst.data", ia.flit_data, 32'h0);
    chk("arst.busy", ia.busy, 1'b0);
    chk("arst.err", ia.credit_err, 1'b0);
    chk("arst.ready", ia.src_ready, 4'h0);
    chk("arst.cred0", dut_a.credit[0], 3'd4);
    chk("arst.cred1", dut_a.credit[1], 3'd4);
    tick();
    arst = 1'b0;
    drv_a(4'hF, 4'hF, 32'h50, 2'b00); tick();
    chk("post.busy", ia.busy, 1'b1);
    #1;
    chk("post.ready", ia.src_ready, 4'h1); tick();
    chk("post.fv", ia.flit_valid, 1'b1);
    chk("post.vc", ia.flit_vc, 1'b0);
    chk("post.data", ia.flit_data, 32'h50);
    chk("post.headtail", {ia.flit_head, ia.flit_tail}, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_inject_sched.md
Name: noc_inject_sched

Overview:
- Injection scheduler in front of one router's local port.
- Shares the port between NUM_REQ packet sources with packet-level round-robin and picks a VC per packet.
- Tracks per-VC downstream credits and emits head/body/tail-tagged flits one per cycle.
- Holds requester and VC ownership for a whole packet (wormhole); the integration layer packs flit_* into the local channel word.

Parameters:
- NUM_REQ, 4, number of packet sources (>=2).
- NUM_VCS, 2, virtual channels on the local link (>=1).
- CREDITS, 4, per-VC downstream buffer depth; also the credit counter reset value.
- DATA_W, 32, flit payload width.

Ports:
- clk  in  1  clock.
- arst  in  1  asynchronous reset, active-high.
- src_valid  in  NUM_REQ  source i presents a flit.
- src_data  in  NUM_REQ*DATA_W  source i payload in bits [i*DATA_W +: DATA_W].
- src_last  in  NUM_REQ  presented flit is the packet's tail.
- src_ready  out  NUM_REQ  combinational accept strobe, one-hot or zero.
- flit_valid  out  1  registered flit strobe to router.
- flit_vc  out  $clog2(NUM_VCS) (min 1)  VC of the flit.
- flit_head  out  1  first flit of packet.
- flit_tail  out  1  last flit of packet.
- flit_data  out  DATA_W  payload.
- credit_in  in  NUM_VCS  one-cycle pulse per VC; each pulse returns one credit.
- busy  out  1  packet in progress (state SEND).
- credit_err  out  1  sticky credit overflow flag.

Behaviour:
- Reset (async, arst=1): state IDLE; all credit counters = CREDITS; req pointer = NUM_REQ-1 and VC pointer = NUM_VCS-1, so req0 and vc0 win first.
- Reset values of outputs: flit_valid, flit_head, flit_tail, busy, credit_err = 0; flit_vc, flit_data = 0; src_ready = 0.
- Reset mid-packet aborts the packet with no tail emitted. Upstream flush is the system's responsibility.
- FSM IDLE:
  - If any src_valid and at least one VC has credit>0, grant the first valid source searching from req pointer+1 (wrap).
  - Pick VC as the first VC with credit>0 searching from VC pointer+1 (wrap).
  - Register owner and vc, update both pointers to the winners, set the first-flit flag, go to SEND.
  - src_ready = 0 in IDLE.
  - No valid source, or no VC with credit: stay IDLE.
- FSM SEND:
  - src_ready[owner] = src_valid[owner] && credit[vc] > 0; all other src_ready = 0.
  - On handshake, the next cycle drives: flit_valid=1, flit_vc=vc, flit_data=src_data[owner], flit_head=first-flit flag, flit_tail=src_last[owner].
  - On handshake the first-flit flag clears. If src_last, go to IDLE.
  - No handshake: flit_valid=0 next cycle; state held. Stall on empty source or zero credit is unbounded.
- Latency and throughput:
  - flit output 1 cycle after handshake.
  - Sustained 1 flit/cycle within a packet.
  - One IDLE arbitration cycle between packets.
  - A 1-flit packet carries flit_head=flit_tail=1.
- Credit counters (width $clog2(CREDITS+1)), per VC per cycle:
  - send only: -1.
  - credit_in only: +1.
  - both: unchanged.
  - A send never occurs at 0; this is guaranteed by the src_ready gating.
  - credit_in with counter == CREDITS and no same-cycle send: counter saturates and credit_err sets. It clears only on reset.
  - credit_in on a VC not owned by the current packet is still counted.
- Grant stability: owner and vc do not change in SEND even when other sources assert src_valid or other VCs gain credit.
- busy = (state == SEND).

Test Plan:
- Single packet: src0 sends 3 flits (D0, D1, D2 with last on D2), CREDITS=4.
  - Required: flits on vc0 with head on D0 only and tail on D2 only, on consecutive cycles.
  - credit[0]=1 afterwards; busy falls the cycle after the D2 handshake.
- Round robin: all 4 sources hold 1-flit packets continuously with credits returned each cycle.
  - Required: grant order 0,1,2,3,0; VCs alternate 0,1,0,1.
  - Each flit has head=tail=1, one every 2 cycles.
- Credit stall: CREDITS=2, 4-flit packet on vc0, no credit_in.
  - Required: 2 flits emitted, then src_ready=0 and flit_valid=0.
  - One credit_in[0] pulse produces exactly one further flit one cycle after the next handshake.
- VC skip: credit[0]=0, credit[1]=3, VC pointer=1.
  - Required: the next packet uses vc1, since vc0 has no credit. With both VCs at 0, the FSM stays IDLE while sources are valid.
- Simultaneous: credit_in[0] in the same cycle as a send on vc0 at credit=1.
  - Required: counter stays 1 and the next flit proceeds without a stall.
- Error and reset: credit_in[1] at credit=CREDITS with no send -> credit_err=1 next cycle, counter stays CREDITS.
  - Assert arst mid-packet -> all outputs 0 immediately and counters back to CREDITS.
  - After release, req0 and vc0 win first.
